step_tracker: RTL
=================

STEP_TRACKER -- requirements
Module: step_tracker

Interface
REQ-001 Parameter CLKS_PER_SEC, default 100000000, clock cycles per measurement second; benches override to a small value such as 100.
REQ-002 clk100Mhz  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pulse  input  1  step pulse from the step pulse generator, synchronous to clk100Mhz.
REQ-005 step_count  output  14  total steps since reset, saturating at 9999.
REQ-006 step_sat  output  1  high while step_count = 9999.
REQ-007 distance_hm  output  4  distance in half-mile units = floor(step_count/1024), range 0..9.
REQ-008 over32_secs  output  4  number of seconds among seconds 1..9 after reset with more than 32 steps, range 0..9.
REQ-009 high_act_secs  output  16  accumulated high-activity seconds, saturating at 65535.
REQ-010 sec_tick  output  1  one-cycle strobe on the last cycle of each measurement second.

Function
REQ-011 A step SHALL be one rising edge of pulse (pulse=1 with previous-cycle pulse=0); a pulse held high for N cycles counts once.
REQ-012 Edge detection SHALL use one registered copy of pulse; step_count SHALL update the cycle after the edge cycle (latency 1).
REQ-013 step_count SHALL increment by 1 per step below 9999 and SHALL hold at 9999; step_sat SHALL be combinationally derived from step_count.
REQ-014 distance_hm SHALL be step_count[13:10], with no extra register.
REQ-015 A second timer SHALL count 0..CLKS_PER_SEC-1 and wrap; sec_tick SHALL be 1 exactly when the timer equals CLKS_PER_SEC-1.
REQ-016 A per-second step counter (8 bits, saturating at 255) SHALL count steps within the current second.
REQ-017 A step detected in the sec_tick cycle SHALL count toward the ending second; the per-second counter SHALL restart at 0 on the next cycle.
REQ-018 A second-index counter SHALL count completed seconds from 0 and saturate at 15.
REQ-019 On sec_tick with second index < 9 and per-second count (including any same-cycle step) > 32, over32_secs SHALL increment; after 9 completed seconds it SHALL freeze.
REQ-020 A second is "high" when its final per-second count is >= 64.
REQ-021 A run counter (saturating at 60) SHALL increment on each high second and clear to 0 on each non-high second.
REQ-022 On the high second that brings the run counter to 60, high_act_secs SHALL add 60; on each later consecutive high second it SHALL add 1; all additions SHALL saturate at 65535.
REQ-023 A non-high second SHALL leave high_act_secs unchanged; a run shorter than 60 seconds SHALL contribute nothing.
REQ-024 All outputs except step_sat and distance_hm SHALL be registered.

Reset
REQ-025 While rst=1 on a clock edge, step_count, over32_secs, high_act_secs, sec_tick, the second timer, the per-second counter, the second index, the run counter and the pulse history register SHALL all clear to 0.
REQ-026 Reset asserted mid-second SHALL discard the partial second; the first second after reset SHALL start at the first cycle with rst=0.
REQ-027 If pulse is already high when rst deasserts, that cycle SHALL count as a step, because the history register is 0.

Structure
REQ-028 Shared package fitbit_pkg SHALL hold STEP_SAT=9999, STEPS_PER_HALF_MILE=1024, OVER_THRESH=32, HIGH_THRESH=64, HIGH_RUN_MIN=60 and WINDOW_SECS=9.
REQ-029 The second timer with sec_tick SHALL be a sub-module sec_timer, parameterised by CLKS_PER_SEC; all other logic SHALL live in step_tracker.

Verification (CLKS_PER_SEC=100)
REQ-030 Apply 5 one-cycle pulses, then a single pulse held 10 cycles -> step_count=6, distance_hm=0.
REQ-031 Apply 40 steps per second for 12 seconds -> over32_secs=9 after second 9 and still 9 after second 12; high_act_secs=0.
REQ-032 Apply exactly 32 steps in second 1 and 33 in second 2 -> over32_secs=1; place the 33rd step in the sec_tick cycle and confirm it counts toward second 2.
REQ-033 Apply 64 steps per second for 59 seconds, one 10-step second, then 61 high seconds -> high_act_secs=0 through the first run, 60 at the 60th second of the second run, 61 after the 61st.
REQ-034 Apply 10500 steps -> step_count=9999, step_sat=1, distance_hm=9; distance_hm=1 exactly when step_count reaches 1024.
REQ-035 Assert rst for 1 cycle mid-second with all counters nonzero -> all outputs 0 next cycle; the next sec_tick occurs exactly CLKS_PER_SEC cycles after rst deasserts.

Source files
------------

// File: rtl/fitbit_pkg.sv
// Shared constants and helpers for the fitness-tracker datapath.
package fitbit_pkg;

  localparam logic [13:0] STEP_SAT            = 14'd9999;
  localparam int          STEPS_PER_HALF_MILE = 1024;
  localparam logic [7:0]  OVER_THRESH         = 8'd32;
  localparam logic [7:0]  HIGH_THRESH         = 8'd64;
  localparam logic [5:0]  HIGH_RUN_MIN        = 6'd60;
  localparam logic [3:0]  WINDOW_SECS         = 4'd9;

  // Unsigned 16-bit add that clamps at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Free-running measurement-second timer; sec_tick marks the last cycle of each second.
module sec_timer #(
  parameter int CLKS_PER_SEC = 100000000
) (
  input  logic clk100Mhz,
  input  logic rst,
  output logic sec_tick
);

  localparam int W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_SEC - 1);
  localparam logic [W-1:0] PRE  = (CLKS_PER_SEC > 1) ? W'(CLKS_PER_SEC - 2) : '0;

  logic [W-1:0] count;

  // The tick is registered one cycle early so it is high exactly while count == LAST.
  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      count    <= '0;
      sec_tick <= 1'b0;
    end else begin
      count    <= (count == LAST) ? '0 : count + W'(1);
      sec_tick <= (CLKS_PER_SEC == 1) || (count == PRE);
    end
  end

endmodule

// File: rtl/step_tracker.sv
// Step counter with distance, per-second activity windows and high-activity accounting.
module step_tracker
  import fitbit_pkg::*;
#(
  parameter int CLKS_PER_SEC = 100000000
) (
  input  logic        clk100Mhz,
  input  logic        rst,
  input  logic        pulse,
  output logic [13:0] step_count,
  output logic        step_sat,
  output logic [3:0]  distance_hm,
  output logic [3:0]  over32_secs,
  output logic [15:0] high_act_secs,
  output logic        sec_tick
);

  localparam logic [5:0] HIGH_RUN_LAST = HIGH_RUN_MIN - 6'd1;

  logic       pulse_d;
  logic       step;
  logic [7:0] sec_steps;
  logic [7:0] sec_final;
  logic [3:0] sec_idx;
  logic [5:0] run_len;
  logic       high_sec;

  sec_timer #(
    .CLKS_PER_SEC(CLKS_PER_SEC)
  ) u_sec_timer (
    .clk100Mhz(clk100Mhz),
    .rst      (rst),
    .sec_tick (sec_tick)
  );

  // sec_final folds in a step landing on the tick cycle so it belongs to the ending second.
  assign step        = pulse & ~pulse_d;
  assign sec_final   = (step && sec_steps != 8'hFF) ? sec_steps + 8'd1 : sec_steps;
  assign high_sec    = (sec_final >= HIGH_THRESH);
  assign step_sat    = (step_count == STEP_SAT);
  assign distance_hm = step_count[13:10];

  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      pulse_d       <= 1'b0;
      step_count    <= '0;
      sec_steps     <= '0;
      sec_idx       <= '0;
      run_len       <= '0;
      over32_secs   <= '0;
      high_act_secs <= '0;
    end else begin
      pulse_d <= pulse;
      if (step && step_count < STEP_SAT)
        step_count <= step_count + 14'd1;

      if (sec_tick) begin
        sec_steps <= '0;
        if (sec_idx != 4'hF)
          sec_idx <= sec_idx + 4'd1;
        if (sec_idx < WINDOW_SECS && sec_final > OVER_THRESH)
          over32_secs <= over32_secs + 4'd1;

        // A run earns nothing until its 60th second, then credits the whole minute at once.
        if (high_sec) begin
          if (run_len < HIGH_RUN_MIN)
            run_len <= run_len + 6'd1;
          if (run_len == HIGH_RUN_LAST)
            high_act_secs <= sat_add16(high_act_secs, 16'(HIGH_RUN_MIN));
          else if (run_len == HIGH_RUN_MIN)
            high_act_secs <= sat_add16(high_act_secs, 16'd1);
        end else begin
          run_len <= '0;
        end
      end else begin
        sec_steps <= sec_final;
      end
    end
  end

endmodule
